demo_scene_sequencer: RTL
=========================

// Module: demo_scene_sequencer
// PURPOSE
//  Frame-level scheduler for demo_top. Counts frames from the video new_frame pulse and steps
//  the active scene through a NUM_SCENES playlist, each scene lasting a programmable number
//  of frames. Implements pause, single-frame step (advance_frame), scene skip and scene hold.
//  Drives scene index, frame-in-scene, global frame count and fade level to the render/audio datapath.
// PARAMETERS
//  NUM_SCENES   8   scenes in playlist; scene index wraps NUM_SCENES-1 -> 0
//  SCENE_BITS   3   width of scene index, 2**SCENE_BITS >= NUM_SCENES
//  LEN_BITS     8   width of scene length / frame-in-scene counter
//  FRAME_BITS   12  width of global frame counter (free-running, wraps)
//  FADE_BITS    4   width of fade level; FADE_MAX = 2**FADE_BITS-1
// PORTS
//  clk            in   1           clock
//  reset          in   1           synchronous reset, active high
//  new_frame      in   1           one-cycle pulse at start of each video frame
//  pause          in   1           level; freezes frame advance (ext_control pause bit)
//  step           in   1           level (advance_frame); rising edge requests one frame while paused
//  skip           in   1           level; rising edge requests jump to next scene
//  hold_scene     in   1           level; loop current scene instead of advancing at its end
//  scene_len      in   LEN_BITS    length in frames of current scene (ROM indexed by scene); 0 treated as 1
//  scene          out  SCENE_BITS  active scene index
//  frame_in_scene out  LEN_BITS    frames elapsed in current scene
//  frame_count    out  FRAME_BITS  total frames advanced since reset
//  scene_start    out  1           one-cycle pulse: scene (re)entered this cycle
//  fade           out  FADE_BITS   min(frame_in_scene, scene_len-1-frame_in_scene, FADE_MAX)
// BEHAVIOUR
//  - Reset: state=RUN; scene, frame_in_scene, frame_count, fade = 0; scene_start=0; step/skip edge regs=0, skip_pend=0.
//  - All outputs registered; everything updates the cycle after a qualifying new_frame (latency 1).
//  - step_rise = step & !step_q; skip_rise = skip & !skip_q (edge regs sample every cycle).
//  - FSM: RUN: pause=1 -> PAUSED.  PAUSED: pause=0 -> RUN; else step_rise -> STEP.
//    STEP: on new_frame advance once, then -> PAUSED if pause=1 else RUN. Non-frame cycles: STEP held.
//  - adv = new_frame & ((state==RUN & !pause) | state==STEP). pause and new_frame same cycle in RUN: no advance.
//  - skip_rise sets skip_pend; skip_pend cleared when consumed. Consumed on the next new_frame in ANY state
//    (skip works while paused); skip_rise and consume same cycle: consumed, pend stays 0.
//  - On adv or skip consume: frame_count <= frame_count+1 (mod 2**FRAME_BITS) only if adv.
//  - len_eff = (scene_len==0) ? 1 : scene_len. last = (frame_in_scene >= len_eff-1).
//  - Scene change when (adv & last) or skip consume: frame_in_scene<=0, scene_start<=1,
//    scene <= hold_scene & !skip_pend ? scene : (scene==NUM_SCENES-1 ? 0 : scene+1). Skip beats hold.
//  - Otherwise on adv: frame_in_scene <= frame_in_scene+1. scene_start=0 on all other cycles.
//  - fade recomputed from the NEXT frame_in_scene and len_eff, saturating at FADE_MAX; 0 on scene entry.
//  - scene_len may change when scene changes; it is sampled combinationally every cycle (no latching).
//  - Reset mid-frame/mid-step: immediate return to reset values; pending step/skip discarded.
// TESTING
//  - Reset, scene_len=3, 10 new_frame pulses -> scene 0,0,0,1,1,1,2.. ; scene_start pulses after frames 3,6,9; frame_count=10.
//  - pause=1 across 5 new_frame -> all counters frozen; two step rising edges -> frame_count +2 exactly, state back to PAUSED.
//  - scene=NUM_SCENES-1 at last frame, new_frame -> scene=0, frame_in_scene=0, scene_start=1.
//  - hold_scene=1, scene_len=2, 6 frames -> scene unchanged, frame_in_scene 0,1,0,1..; skip edge -> scene+1 at next frame.
//  - paused + skip edge -> scene advances at next new_frame, frame_count unchanged; scene_len=0 -> scene changes every frame.
//  - scene_len=40, FADE_MAX=15 -> fade ramps 0..15, holds 15, ramps down to 0 at frame 39; reset mid-ramp -> all zeros next cycle.

Source files
------------

// File: rtl/demo_scene_sequencer.sv
// Frame-level scene scheduler: advances a scene playlist on video frame pulses, with pause,
// single-frame step, scene skip and scene hold. All outputs are registered.
module demo_scene_sequencer #(
    parameter int unsigned NUM_SCENES = 8,
    parameter int unsigned SCENE_BITS = 3,
    parameter int unsigned LEN_BITS   = 8,
    parameter int unsigned FRAME_BITS = 12,
    parameter int unsigned FADE_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_frame,
    input  logic                  pause,
    input  logic                  step,
    input  logic                  skip,
    input  logic                  hold_scene,
    input  logic [LEN_BITS-1:0]   scene_len,
    output logic [SCENE_BITS-1:0] scene,
    output logic [LEN_BITS-1:0]   frame_in_scene,
    output logic [FRAME_BITS-1:0] frame_count,
    output logic                  scene_start,
    output logic [FADE_BITS-1:0]  fade
);

    localparam logic [SCENE_BITS-1:0] LastScene  = SCENE_BITS'(NUM_SCENES - 1);
    localparam int unsigned           FadeMaxInt = (1 << FADE_BITS) - 1;
    localparam logic [LEN_BITS-1:0]   FadeMaxLen = LEN_BITS'(FadeMaxInt);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StPaused = 2'd1,
        StStep   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [SCENE_BITS-1:0] scene_q, scene_d;
    logic [LEN_BITS-1:0]   fis_q, fis_d;
    logic [FRAME_BITS-1:0] fc_q, fc_d;
    logic                  start_q, start_d;
    logic [FADE_BITS-1:0]  fade_q, fade_d;
    logic                  step_q, skip_q;
    logic                  skip_pend_q, skip_pend_d;

    logic                step_rise, skip_rise, skip_req, skip_take;
    logic                adv, last, change;
    logic [LEN_BITS-1:0] len_eff, len_m1;

    // Edge detection, frame qualification and scene-end decode.
    always_comb begin
        step_rise = step & ~step_q;
        skip_rise = skip & ~skip_q;
        skip_req  = skip_pend_q | skip_rise;
        // A skip is honoured on the next frame pulse regardless of pause state.
        skip_take = new_frame & skip_req;
        adv       = new_frame & (((state_q == StRun) & ~pause) | (state_q == StStep));
        len_eff   = (scene_len == '0) ? LEN_BITS'(1) : scene_len;
        len_m1    = len_eff - LEN_BITS'(1);
        last      = (fis_q >= len_m1);
        change    = (adv & last) | skip_take;
    end

    // Playback control FSM next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (pause) state_d = StPaused;
            end
            StPaused: begin
                if (!pause)         state_d = StRun;
                else if (step_rise) state_d = StStep;
            end
            StStep: begin
                if (new_frame) state_d = pause ? StPaused : StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // Scene / frame counters and fade level for the next registered value.
    always_comb begin
        logic [LEN_BITS-1:0] f_down;
        logic [LEN_BITS-1:0] f_min;

        scene_d     = scene_q;
        fis_d       = fis_q;
        fc_d        = fc_q;
        start_d     = 1'b0;
        fade_d      = fade_q;
        skip_pend_d = skip_take ? 1'b0 : skip_req;
        f_down      = '0;
        f_min       = '0;

        if (adv) fc_d = fc_q + 1'b1;

        if (change) begin
            fis_d   = '0;
            start_d = 1'b1;
            // Skip overrides hold.
            if (!(hold_scene && !skip_take)) begin
                scene_d = (scene_q == LastScene) ? '0 : scene_q + 1'b1;
            end
        end else if (adv) begin
            fis_d = fis_q + 1'b1;
        end

        if (adv || skip_take) begin
            // Frames beyond a shortened scene length fade as fully out.
            f_down = (fis_d <= len_m1) ? (len_m1 - fis_d) : '0;
            f_min  = (fis_d < f_down) ? fis_d : f_down;
            fade_d = (f_min > FadeMaxLen) ? FADE_BITS'(FadeMaxInt) : f_min[FADE_BITS-1:0];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            scene_q     <= '0;
            fis_q       <= '0;
            fc_q        <= '0;
            start_q     <= 1'b0;
            fade_q      <= '0;
            step_q      <= 1'b0;
            skip_q      <= 1'b0;
            skip_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            scene_q     <= scene_d;
            fis_q       <= fis_d;
            fc_q        <= fc_d;
            start_q     <= start_d;
            fade_q      <= fade_d;
            step_q      <= step;
            skip_q      <= skip;
            skip_pend_q <= skip_pend_d;
        end
    end

    assign scene          = scene_q;
    assign frame_in_scene = fis_q;
    assign frame_count    = fc_q;
    assign scene_start    = start_q;
    assign fade           = fade_q;

endmodule
